// File: rtl/render_pkg.sv
// Shared rendering types and defaults for the snake generator, painter and VGA timing side.
// Coordinate widths are fixed at 10-bit x and 9-bit y.
package render_pkg;

   localparam int unsigned XWidth    = 10;
   localparam int unsigned YWidth    = 9;
   localparam int unsigned DefHRes   = 640;
   localparam int unsigned DefVRes   = 480;
   localparam int unsigned DefColorW = 8;

   localparam logic [DefColorW-1:0] DefBgColor = '0;
   localparam logic [DefColorW-1:0] DefFgColor = '1;

   typedef enum logic [2:0] {
      StIdle,
      StClear,
      StHandoff,
      StDraw,
      StDone
   } paint_state_t;

endpackage

// File: rtl/frame_painter_if.sv
// Coordinate stream in, pixel-RAM write port and status out of the frame painter.
// master = generator/host side, slave = painter.
interface frame_painter_if
   import render_pkg::*;
#(
   parameter int unsigned COLOR_W = DefColorW
);
   logic               frame_start;
   logic [XWidth-1:0]  rx;
   logic [YWidth-1:0]  ry;
   logic               rvalid;
   logic               write_done;
   logic               cleared;
   logic [XWidth-1:0]  pix_x;
   logic [YWidth-1:0]  pix_y;
   logic [COLOR_W-1:0] pix_color;
   logic               pix_we;
   logic               busy;
   logic               frame_done;
   logic [15:0]        frame_count;
   logic [15:0]        clip_count;
   logic               overrun;

   modport master (
      output frame_start, rx, ry, rvalid, write_done,
      input  cleared, pix_x, pix_y, pix_color, pix_we, busy, frame_done, frame_count,
             clip_count, overrun
   );

   modport slave (
      input  frame_start, rx, ry, rvalid, write_done,
      output cleared, pix_x, pix_y, pix_color, pix_we, busy, frame_done, frame_count,
             clip_count, overrun
   );
endinterface

// File: rtl/raster_scan.sv
// Raster counter: cx runs 0..H_RES-1, then wraps and bumps cy; both wrap after the last pixel.
// last_o flags (H_RES-1, V_RES-1) combinationally from the registered count.
module raster_scan
   import render_pkg::*;
#(
   parameter int unsigned H_RES = DefHRes,
   parameter int unsigned V_RES = DefVRes
) (
   input  logic              draw_clk,
   input  logic              reset,
   input  logic              en_i,
   input  logic              clr_i,
   output logic [XWidth-1:0] cx_o,
   output logic [YWidth-1:0] cy_o,
   output logic              last_o
);
   localparam logic [XWidth-1:0] XLast = XWidth'(H_RES - 1);
   localparam logic [YWidth-1:0] YLast = YWidth'(V_RES - 1);

   logic [XWidth-1:0] cx_q, cx_d;
   logic [YWidth-1:0] cy_q, cy_d;

   always_comb begin
      cx_d = cx_q;
      cy_d = cy_q;
      if (clr_i) begin
         cx_d = '0;
         cy_d = '0;
      end else if (en_i) begin
         if (cx_q == XLast) begin
            cx_d = '0;
            cy_d = (cy_q == YLast) ? '0 : cy_q + 1'b1;
         end else begin
            cx_d = cx_q + 1'b1;
         end
      end
   end

   always_ff @(posedge draw_clk or posedge reset) begin
      if (reset) begin
         cx_q <= '0;
         cy_q <= '0;
      end else begin
         cx_q <= cx_d;
         cy_q <= cy_d;
      end
   end

   assign cx_o   = cx_q;
   assign cy_o   = cy_q;
   assign last_o = (cx_q == XLast) && (cy_q == YLast);
endmodule

// File: rtl/frame_painter.sv
// Per-frame painter: sweep-clear the pixel buffer, hand off to the generator, then turn each
// streamed coordinate into a foreground write until the generator reports done.
module frame_painter
   import render_pkg::*;
#(
   parameter int unsigned         H_RES    = DefHRes,
   parameter int unsigned         V_RES    = DefVRes,
   parameter int unsigned         COLOR_W  = DefColorW,
   parameter logic [COLOR_W-1:0]  BG_COLOR = '0,
   parameter logic [COLOR_W-1:0]  FG_COLOR = '1
) (
   input logic            draw_clk,
   input logic            reset,
   frame_painter_if.slave bus
);
   localparam logic [XWidth-1:0] XMax = XWidth'(H_RES - 1);
   localparam logic [YWidth-1:0] YMax = YWidth'(V_RES - 1);

   paint_state_t       state_q, state_d;
   logic               armed_q, armed_d;
   logic [XWidth-1:0]  pix_x_q, pix_x_d;
   logic [YWidth-1:0]  pix_y_q, pix_y_d;
   logic [COLOR_W-1:0] pix_color_q, pix_color_d;
   logic               pix_we_q, pix_we_d;
   logic               cleared_q, cleared_d;
   logic               busy_q, busy_d;
   logic               frame_done_q, frame_done_d;
   logic [15:0]        frame_count_q, frame_count_d;
   logic [15:0]        clip_count_q, clip_count_d;
   logic               overrun_q, overrun_d;

   logic              scan_en, scan_clr, scan_last;
   logic [XWidth-1:0] cx;
   logic [YWidth-1:0] cy;
   logic              in_range;

   raster_scan #(
      .H_RES (H_RES),
      .V_RES (V_RES)
   ) u_raster_scan (
      .draw_clk (draw_clk),
      .reset    (reset),
      .en_i     (scan_en),
      .clr_i    (scan_clr),
      .cx_o     (cx),
      .cy_o     (cy),
      .last_o   (scan_last)
   );

   assign in_range = (bus.rx <= XMax) && (bus.ry <= YMax);

   // Outputs are computed one state ahead so every port comes straight from a flop.
   always_comb begin
      state_d       = state_q;
      armed_d       = armed_q;
      pix_x_d       = pix_x_q;
      pix_y_d       = pix_y_q;
      pix_color_d   = pix_color_q;
      pix_we_d      = 1'b0;
      cleared_d     = 1'b0;
      frame_done_d  = 1'b0;
      frame_count_d = frame_count_q;
      clip_count_d  = clip_count_q;
      overrun_d     = overrun_q | (bus.frame_start && (state_q != StIdle));
      scan_en       = 1'b0;
      scan_clr      = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (bus.frame_start) begin
               pix_we_d    = 1'b1;
               pix_x_d     = cx;
               pix_y_d     = cy;
               pix_color_d = BG_COLOR;
               scan_en     = 1'b1;
               state_d     = StClear;
            end else begin
               scan_clr = 1'b1;
            end
         end
         StClear: begin
            pix_we_d    = 1'b1;
            pix_x_d     = cx;
            pix_y_d     = cy;
            pix_color_d = BG_COLOR;
            scan_en     = 1'b1;
            if (scan_last) state_d = StHandoff;
         end
         StHandoff: begin
            cleared_d = 1'b1;
            armed_d   = 1'b0;
            state_d   = StDraw;
         end
         StDraw: begin
            if (!bus.write_done) armed_d = 1'b1;
            if (bus.rvalid) begin
               if (in_range) begin
                  pix_we_d    = 1'b1;
                  pix_x_d     = bus.rx;
                  pix_y_d     = bus.ry;
                  pix_color_d = FG_COLOR;
               end else if (clip_count_q != 16'hFFFF) begin
                  clip_count_d = clip_count_q + 16'd1;
               end
            end
            if (armed_q && bus.write_done) begin
               frame_done_d  = 1'b1;
               frame_count_d = frame_count_q + 16'd1;
               state_d       = StDone;
            end
         end
         StDone: state_d = StIdle;
         default: state_d = StIdle;
      endcase

      busy_d = (state_d != StIdle);
   end

   always_ff @(posedge draw_clk or posedge reset) begin
      if (reset) begin
         state_q       <= StIdle;
         armed_q       <= 1'b0;
         pix_x_q       <= '0;
         pix_y_q       <= '0;
         pix_color_q   <= '0;
         pix_we_q      <= 1'b0;
         cleared_q     <= 1'b0;
         busy_q        <= 1'b0;
         frame_done_q  <= 1'b0;
         frame_count_q <= '0;
         clip_count_q  <= '0;
         overrun_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         armed_q       <= armed_d;
         pix_x_q       <= pix_x_d;
         pix_y_q       <= pix_y_d;
         pix_color_q   <= pix_color_d;
         pix_we_q      <= pix_we_d;
         cleared_q     <= cleared_d;
         busy_q        <= busy_d;
         frame_done_q  <= frame_done_d;
         frame_count_q <= frame_count_d;
         clip_count_q  <= clip_count_d;
         overrun_q     <= overrun_d;
      end
   end

   assign bus.pix_x       = pix_x_q;
   assign bus.pix_y       = pix_y_q;
   assign bus.pix_color   = pix_color_q;
   assign bus.pix_we      = pix_we_q;
   assign bus.cleared     = cleared_q;
   assign bus.busy        = busy_q;
   assign bus.frame_done  = frame_done_q;
   assign bus.frame_count = frame_count_q;
   assign bus.clip_count  = clip_count_q;
   assign bus.overrun     = overrun_q;
endmodule

// File: tb/tb_frame_painter.sv
// Bench for frame_painter on a 4x3 screen: scripted and random frames checked against a
// behavioural model of the expected write list, clip/frame counters and overrun flag.
module tb_frame_painter;
   localparam int unsigned HRes = 4;
   localparam int unsigned VRes = 3;
   localparam int unsigned NPix = HRes * VRes;
   localparam logic [7:0]  Bg   = 8'h00;
   localparam logic [7:0]  Fg   = 8'hFF;

   typedef struct {int x; int y; bit v;} coord_t;

   logic draw_clk = 1'b0;
   logic reset    = 1'b1;
   int   n_cmp    = 0;
   int   n_bad    = 0;
   int   exp_frames = 0;
   int   exp_clip   = 0;
   bit   exp_ovr    = 1'b0;
   coord_t stim_q[$];

   frame_painter_if #(.COLOR_W(8)) bus ();

   frame_painter #(
      .H_RES    (HRes),
      .V_RES    (VRes),
      .COLOR_W  (8),
      .BG_COLOR (Bg),
      .FG_COLOR (Fg)
   ) dut (
      .draw_clk (draw_clk),
      .reset    (reset),
      .bus      (bus.slave)
   );

   always #5 draw_clk = ~draw_clk;

   task automatic tick();
      @(posedge draw_clk);
      #1;
   endtask

   // One frame_start followed by the full background sweep and the handoff cycle.
   task automatic run_clear(input bit inject_start);
      bus.frame_start = 1'b1;
      for (int i = 0; i < int'(NPix); i++) begin
         tick();
         bus.frame_start = 1'b0;
         n_cmp++;
         if (bus.pix_we !== 1'b1 || bus.pix_x !== 10'(i % HRes) || bus.pix_y !== 9'(i / HRes) ||
             bus.pix_color !== Bg || bus.cleared !== 1'b0 || bus.busy !== 1'b1) begin
            n_bad++;
            $display("FAIL clear_write[%0d]: got we=%b x=%0d y=%0d c=%h cleared=%b busy=%b, want we=1 x=%0d y=%0d c=%h cleared=0 busy=1",
                     i, bus.pix_we, bus.pix_x, bus.pix_y, bus.pix_color, bus.cleared, bus.busy,
                     i % HRes, i / HRes, Bg);
         end
         if (inject_start && i == 2) begin
            bus.frame_start = 1'b1;
            exp_ovr = 1'b1;
         end
         // Stray stream traffic outside DRAW must be ignored.
         bus.rvalid = 1'($urandom_range(0, 1));
         bus.rx     = 10'($urandom_range(0, 5));
         bus.ry     = 9'($urandom_range(0, 4));
      end
      tick();
      bus.rvalid = 1'b0;
      n_cmp++;
      if (bus.cleared !== 1'b1 || bus.pix_we !== 1'b0 || bus.busy !== 1'b1 ||
          bus.clip_count !== 16'(exp_clip) || bus.overrun !== exp_ovr) begin
         n_bad++;
         $display("FAIL handoff: got cleared=%b we=%b busy=%b clip=%0d ovr=%b, want cleared=1 we=0 busy=1 clip=%0d ovr=%b",
                  bus.cleared, bus.pix_we, bus.busy, bus.clip_count, bus.overrun, exp_clip, exp_ovr);
      end
   endtask

   // Stream stim_q (write_done low), then raise write_done with an optional last coordinate.
   task automatic run_stream(input bit fv, input int fx, input int fy);
      bit inr;
      bus.write_done = 1'b0;
      if (stim_q.size() == 0) stim_q.push_back('{x: 0, y: 0, v: 1'b0});
      foreach (stim_q[j]) begin
         bus.rvalid = stim_q[j].v;
         bus.rx     = 10'(stim_q[j].x);
         bus.ry     = 9'(stim_q[j].y);
         tick();
         inr = stim_q[j].v && stim_q[j].x < int'(HRes) && stim_q[j].y < int'(VRes);
         if (stim_q[j].v && !inr && exp_clip < 65535) exp_clip++;
         n_cmp++;
         if (inr ? (bus.pix_we !== 1'b1 || bus.pix_x !== 10'(stim_q[j].x) ||
                    bus.pix_y !== 9'(stim_q[j].y) || bus.pix_color !== Fg)
                 : (bus.pix_we !== 1'b0)) begin
            n_bad++;
            $display("FAIL stream_write[%0d]: got we=%b x=%0d y=%0d c=%h, want we=%b x=%0d y=%0d c=%h",
                     j, bus.pix_we, bus.pix_x, bus.pix_y, bus.pix_color, inr,
                     stim_q[j].x, stim_q[j].y, Fg);
         end
         n_cmp++;
         if (bus.clip_count !== 16'(exp_clip) || bus.frame_done !== 1'b0 || bus.cleared !== 1'b0) begin
            n_bad++;
            $display("FAIL stream_status[%0d]: got clip=%0d done=%b cleared=%b, want clip=%0d done=0 cleared=0",
                     j, bus.clip_count, bus.frame_done, bus.cleared, exp_clip);
         end
      end
      stim_q.delete();

      bus.write_done = 1'b1;
      bus.rvalid     = fv;
      bus.rx         = 10'(fx);
      bus.ry         = 9'(fy);
      tick();
      inr = fv && fx < int'(HRes) && fy < int'(VRes);
      if (fv && !inr && exp_clip < 65535) exp_clip++;
      exp_frames = (exp_frames + 1) % 65536;
      n_cmp++;
      if (inr ? (bus.pix_we !== 1'b1 || bus.pix_x !== 10'(fx) || bus.pix_y !== 9'(fy) ||
                 bus.pix_color !== Fg)
              : (bus.pix_we !== 1'b0)) begin
         n_bad++;
         $display("FAIL final_write: got we=%b x=%0d y=%0d c=%h, want we=%b x=%0d y=%0d c=%h",
                  bus.pix_we, bus.pix_x, bus.pix_y, bus.pix_color, inr, fx, fy, Fg);
      end
      n_cmp++;
      if (bus.frame_done !== 1'b1 || bus.frame_count !== 16'(exp_frames) || bus.busy !== 1'b1 ||
          bus.clip_count !== 16'(exp_clip)) begin
         n_bad++;
         $display("FAIL frame_done: got done=%b count=%0d busy=%b clip=%0d, want done=1 count=%0d busy=1 clip=%0d",
                  bus.frame_done, bus.frame_count, bus.busy, bus.clip_count, exp_frames, exp_clip);
      end

      bus.rvalid = 1'b1;
      bus.rx     = 10'd1;
      bus.ry     = 9'd1;
      tick();
      bus.rvalid = 1'b0;
      n_cmp++;
      if (bus.pix_we !== 1'b0 || bus.frame_done !== 1'b0 || bus.busy !== 1'b0 ||
          bus.frame_count !== 16'(exp_frames) || bus.clip_count !== 16'(exp_clip)) begin
         n_bad++;
         $display("FAIL after_done: got we=%b done=%b busy=%b count=%0d clip=%0d, want we=0 done=0 busy=0 count=%0d clip=%0d",
                  bus.pix_we, bus.frame_done, bus.busy, bus.frame_count, bus.clip_count,
                  exp_frames, exp_clip);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_cmp++;
         if ({bus.pix_we, bus.cleared, bus.busy, bus.frame_done, bus.overrun, bus.pix_x,
              bus.pix_y, bus.pix_color, bus.frame_count, bus.clip_count} !== '0) begin
            n_bad++;
            $display("FAIL reset_state[%0d]: got we=%b cl=%b busy=%b done=%b ovr=%b x=%0d y=%0d c=%h fc=%0d cc=%0d, want all 0",
                     i, bus.pix_we, bus.cleared, bus.busy, bus.frame_done, bus.overrun,
                     bus.pix_x, bus.pix_y, bus.pix_color, bus.frame_count, bus.clip_count);
         end
      end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_basic_frame();
      bus.write_done = 1'b1;
      run_clear(1'b0);
      stim_q.push_back('{x: 1, y: 1, v: 1'b1});
      stim_q.push_back('{x: 2, y: 0, v: 1'b1});
      stim_q.push_back('{x: 3, y: 2, v: 1'b1});
      run_stream(1'b0, 0, 0);
   endtask

   task automatic test_clip();
      run_clear(1'b0);
      stim_q.push_back('{x: 4, y: 0, v: 1'b1});
      stim_q.push_back('{x: 0, y: 3, v: 1'b1});
      stim_q.push_back('{x: 0, y: 0, v: 1'b1});
      run_stream(1'b0, 0, 0);
   endtask

   task automatic test_overrun();
      run_clear(1'b1);
      stim_q.push_back('{x: 2, y: 2, v: 1'b1});
      run_stream(1'b0, 0, 0);
      run_clear(1'b0);
      run_stream(1'b0, 0, 0);
   endtask

   task automatic test_same_cycle_done();
      run_clear(1'b0);
      stim_q.push_back('{x: 0, y: 1, v: 1'b1});
      run_stream(1'b1, 3, 1);
   endtask

   task automatic test_random_frames();
      for (int f = 0; f < 4; f++) begin
         run_clear(1'b0);
         for (int k = 0; k < int'($urandom_range(1, 8)); k++)
            stim_q.push_back('{x: int'($urandom_range(0, 5)), y: int'($urandom_range(0, 4)),
                               v: 1'($urandom_range(0, 1))});
         run_stream(1'($urandom_range(0, 1)), int'($urandom_range(0, 5)),
                    int'($urandom_range(0, 4)));
      end
   endtask

   task automatic test_reset_mid_clear();
      bus.frame_start = 1'b1;
      tick();
      bus.frame_start = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      reset = 1'b1;
      #1;
      exp_frames = 0;
      exp_clip   = 0;
      exp_ovr    = 1'b0;
      n_cmp++;
      if ({bus.pix_we, bus.cleared, bus.busy, bus.frame_done, bus.overrun, bus.pix_x,
           bus.pix_y, bus.pix_color, bus.frame_count, bus.clip_count} !== '0) begin
         n_bad++;
         $display("FAIL mid_clear_reset: got we=%b busy=%b x=%0d y=%0d fc=%0d cc=%0d ovr=%b, want all 0",
                  bus.pix_we, bus.busy, bus.pix_x, bus.pix_y, bus.frame_count, bus.clip_count,
                  bus.overrun);
      end
      tick();
      reset = 1'b0;
      tick();
      n_cmp++;
      if (bus.pix_we !== 1'b0 || bus.busy !== 1'b0) begin
         n_bad++;
         $display("FAIL post_reset_idle: got we=%b busy=%b, want we=0 busy=0", bus.pix_we, bus.busy);
      end
      run_clear(1'b0);
      run_stream(1'b0, 0, 0);
   endtask

   initial begin
      bus.frame_start = 1'b0;
      bus.rx          = '0;
      bus.ry          = '0;
      bus.rvalid      = 1'b0;
      bus.write_done  = 1'b1;
      test_reset();
      test_basic_frame();
      test_clip();
      test_overrun();
      test_same_cycle_done();
      test_random_frames();
      test_reset_mid_clear();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/frame_painter.md
# frame_painter

Consumer end of the snake coordinate stream. Once per video frame it wipes the pixel buffer to background, pulses `cleared` so the snake/food generator restarts its walk, then converts every incoming `(rx, ry)` coordinate into a foreground pixel-buffer write until the generator raises `write_done`. It sits between the snake generator and the VGA pixel RAM write port, clocked on `draw_clk`.

## Interface
- `H_RES`, 640, visible width in pixels; clear sweep x range 0..H_RES-1.
- `V_RES`, 480, visible height in pixels; clear sweep y range 0..V_RES-1.
- `COLOR_W`, 8, pixel colour width.
- `BG_COLOR`, 0, colour written during clear.
- `FG_COLOR`, all-ones, colour written for streamed coordinates.
- `draw_clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high.
- `frame_start`  in  1  one-cycle pulse at start of vertical blank.
- `rx`  in  10  streamed x coordinate.
- `ry`  in  9  streamed y coordinate.
- `rvalid`  in  1  `rx`/`ry` valid this cycle.
- `write_done`  in  1  level; generator has finished its stream.
- `cleared`  out  1  one-cycle pulse; generator restart.
- `pix_x`  out  10  write address x.
- `pix_y`  out  9  write address y.
- `pix_color`  out  COLOR_W  write data.
- `pix_we`  out  1  write enable.
- `busy`  out  1  high in every state except IDLE.
- `frame_done`  out  1  one-cycle pulse at end of frame.
- `frame_count`  out  16  completed frames, wraps at 65535 -> 0.
- `clip_count`  out  16  dropped out-of-range coordinates, saturates at 65535.
- `overrun`  out  1  sticky; `frame_start` arrived while busy.

## Operation
- States: IDLE, CLEAR, HANDOFF, DRAW, DONE. All outputs registered.
- IDLE: `frame_start` -> CLEAR; raster counters cx = cy = 0.
- CLEAR: one write per cycle, `pix_we`=1, `pix_color`=BG_COLOR, address (cx, cy). cx increments; at H_RES-1 wraps to 0 and cy increments. The write at (H_RES-1, V_RES-1) is the last; then -> HANDOFF. Exactly H_RES*V_RES writes.
- HANDOFF: `cleared`=1 for exactly this one cycle, `pix_we`=0; `armed` flag cleared; -> DRAW.
- DRAW: `armed` sets on the first cycle `write_done` is sampled low. When `rvalid`=1: if rx < H_RES and ry < V_RES, write (rx, ry) with FG_COLOR; otherwise no write, `clip_count` increments (saturating). Exit to DONE when `armed`=1 and `write_done`=1; a coordinate with `rvalid` in that same cycle is still processed.
- DONE: `frame_done`=1 one cycle, `frame_count` increments; -> IDLE.
- `frame_start` in any non-IDLE state: ignored, `overrun` set, remains set until reset.
- `rvalid` outside DRAW: ignored, no write, no clip count.
- Reset, any time including mid-sweep: state IDLE, cx = cy = 0, `armed`=0, all outputs 0 (`pix_x`, `pix_y`, `pix_color`, `pix_we`, `cleared`, `busy`, `frame_done`, `frame_count`, `clip_count`, `overrun`). No partial write after reset asserts.

## Timing
- `frame_start` sampled at edge n -> first clear write (0,0) visible cycle n+1.
- Last clear write at cycle n+H_RES*V_RES; `cleared` high cycle n+H_RES*V_RES+1.
- Stream latency: `rvalid` sampled at edge m -> `pix_we`/`pix_x`/`pix_y` valid cycle m+1, one write per cycle, no back-pressure (no ready signal); the generator may stream every cycle.
- `write_done`&`armed` sampled at edge k -> `frame_done` high cycle k+1, `busy` low from k+2.
- Minimum frame turnaround: H_RES*V_RES+3 cycles plus stream length.

## Structure
- Package `render_pkg`: state enum `paint_state_t`, default H_RES/V_RES, colour constants, coordinate widths (10-bit x, 9-bit y) shared with the snake generator.
- Sub-module `raster_scan`: cx/cy counter with enable, sync clear, and `last` flag at (H_RES-1, V_RES-1); reused by the VGA timing side.

## Test plan
Run with H_RES=4, V_RES=3.
- Reset, one `frame_start` -> 12 BG writes (0,0),(1,0)..(3,2) on consecutive cycles, then `cleared` high exactly one cycle, `busy`=1.
- Generator holds `write_done`=1 across handoff, drops it the cycle after `cleared`, streams (1,1),(2,0),(3,2), then raises `write_done` -> three FG writes one cycle after each `rvalid`, `frame_done` once, `frame_count`=1.
- Stream (4,0) and (0,3) -> no writes, `clip_count`=2; in-range (0,0) still written.
- `frame_start` during CLEAR -> sweep unaffected, `overrun`=1 and sticky through next frame.
- `reset` asserted at cycle 5 of CLEAR -> all outputs 0 immediately, next `frame_start` restarts sweep at (0,0).
- `rvalid`=1 with `write_done` rising in same DRAW cycle -> that coordinate written, then DONE.
